// File: rtl/rescale_ctrl_pkg.sv
// Shared definitions for the coprocessor control blocks: FSM state encodings,
// rescale pipeline latency and a small population-count helper.
package rescale_ctrl_pkg;

  localparam int unsigned RESCALE_LATENCY = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } ctrl_state_e;

  function automatic logic [2:0] pipe_popcount(input logic [RESCALE_LATENCY-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < RESCALE_LATENCY; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rescale.sv
// Four-stage rescale datapath: arithmetic right shift, then signed saturation
// against the head bit. Data registers are intentionally not reset.
module rescale #(
  parameter int unsigned NUM_WIDTH = 33,
  parameter int unsigned IMG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic [NUM_WIDTH-1:0] i_data,
  input  logic [7:0]           i_shift,
  input  logic [7:0]           i_head,
  output logic [IMG_WIDTH-1:0] o_data
);

  localparam logic [IMG_WIDTH-1:0] SatMax = {1'b0, {(IMG_WIDTH-1){1'b1}}};
  localparam logic [IMG_WIDTH-1:0] SatMin = {1'b1, {(IMG_WIDTH-1){1'b0}}};

  logic signed [NUM_WIDTH-1:0] r_in;
  logic signed [NUM_WIDTH-1:0] r_sh;
  logic        [IMG_WIDTH-1:0] r_val;
  logic                        r_ovf;
  logic                        r_neg;
  logic        [IMG_WIDTH-1:0] r_out;

  logic signed [NUM_WIDTH-1:0] w_hi;
  logic                        w_ovf;

  // Fits iff every bit from the head upward equals the sign bit.
  always_comb begin
    w_hi  = r_sh >>> i_head;
    w_ovf = (w_hi != '0) && (w_hi != '1);
  end

  always_ff @(posedge clk) begin
    r_in  <= i_data;
    r_sh  <= r_in >>> i_shift;
    r_val <= r_sh[IMG_WIDTH-1:0];
    r_ovf <= w_ovf;
    r_neg <= r_sh[NUM_WIDTH-1];
    r_out <= r_ovf ? (r_neg ? SatMin : SatMax) : r_val;
  end

  assign o_data = r_out;

endmodule

// File: rtl/rescale_ctrl.sv
// Job controller around the rescale pipeline: descriptor FSM, credit-based
// input flow control and an output FIFO that can always absorb in-flight words.
module rescale_ctrl
  import rescale_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WIDTH  = 33,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_shift,
  input  logic [7:0]           cfg_head,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic [NUM_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [IMG_WIDTH-1:0] dn_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 2;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

  ctrl_state_e r_state, w_state_d;

  logic [7:0]                 r_shift;
  logic [7:0]                 r_head;
  logic [CNT_WIDTH-1:0]       r_remaining;
  logic [RESCALE_LATENCY-1:0] r_vpipe;
  logic [IMG_WIDTH-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [AW:0]                r_count;
  logic                       r_zero_done;

  logic                 w_cfg_fire;
  logic                 w_up_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_inflight;
  logic [CW-1:0]        w_occupancy;
  logic                 w_drain_exit;
  logic [IMG_WIDTH-1:0] w_rs_data;

  rescale #(
    .NUM_WIDTH(NUM_WIDTH),
    .IMG_WIDTH(IMG_WIDTH)
  ) u_rescale (
    .clk    (clk),
    .i_data (up_data),
    .i_shift(r_shift),
    .i_head (r_head),
    .o_data (w_rs_data)
  );

  // Words in the pipe already own a FIFO slot, so they count against the credit.
  assign w_inflight  = pipe_popcount(r_vpipe);
  assign w_occupancy = {1'b0, r_count} + CW'(w_inflight);

  assign cfg_ready  = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign up_ready   = (r_state == StActive) && (r_remaining != '0) && (w_occupancy < DepthC);
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_up_fire  = up_valid && up_ready;
  assign w_push     = r_vpipe[RESCALE_LATENCY-1];
  assign dn_valid   = (r_count != '0);
  assign w_pop      = dn_valid && dn_ready;
  assign dn_data    = r_mem[r_rptr];
  assign done       = w_drain_exit || r_zero_done;

  always_comb begin
    w_state_d    = r_state;
    w_drain_exit = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cfg_fire && (cfg_count != '0)) w_state_d = StActive;
      end
      StActive: begin
        if (w_up_fire && (r_remaining == CNT_WIDTH'(1))) w_state_d = StDrain;
      end
      StDrain: begin
        if ((w_inflight == 3'd0) && (r_count == '0)) begin
          w_state_d    = StIdle;
          w_drain_exit = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_head      <= '0;
      r_remaining <= '0;
      r_vpipe     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_zero_done <= w_cfg_fire && (cfg_count == '0);
      if (w_cfg_fire) begin
        r_shift     <= cfg_shift;
        r_head      <= cfg_head;
        r_remaining <= cfg_count;
      end else if (w_up_fire) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
      end
      r_vpipe <= {r_vpipe[RESCALE_LATENCY-2:0], w_up_fire};
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rs_data;
  end

endmodule

// File: doc/rescale_ctrl.md
RESCALE_CTRL -- requirements
Module: rescale_ctrl

Interface
REQ-001 Parameter NUM_WIDTH, default 33, sets the MAC/ADD number width of up_data.
REQ-002 Parameter IMG_WIDTH, default 16, sets the image width of dn_data.
REQ-003 Parameter FIFO_DEPTH, default 8, sets the output buffer depth; it SHALL be a power of two and at least 4.
REQ-004 Parameter CNT_WIDTH, default 16, sets the width of the job word count.
REQ-005 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 cfg_valid  in  1  job descriptor valid.
REQ-009 cfg_ready  out  1  descriptor accepted when cfg_valid and cfg_ready are both high.
REQ-010 cfg_shift  in  8  right-shift amount for the job.
REQ-011 cfg_head  in  8  saturation head bit index for the job.
REQ-012 cfg_count  in  CNT_WIDTH  number of words in the job.
REQ-013 up_data  in  NUM_WIDTH  input number.
REQ-014 up_valid / up_ready  in / out  1 each  input handshake.
REQ-015 dn_data  out  IMG_WIDTH  rescaled output word.
REQ-016 dn_valid / dn_ready  out / in  1 each  output handshake.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 done  out  1  one-cycle pulse at job completion.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACTIVE and DRAIN.
REQ-020 In IDLE, cfg_ready SHALL be 1, and a descriptor handshake SHALL latch shift, head and count into internal registers.
REQ-021 In IDLE, a descriptor with count=0 SHALL stay in IDLE and pulse done on the next cycle; any other count SHALL move the FSM to ACTIVE.
REQ-022 The latched shift and head SHALL drive the rescale instance and SHALL change only in IDLE, so they are stable for every word in flight.
REQ-023 In ACTIVE, up_ready SHALL equal (remaining != 0) && (fifo_count + inflight < FIFO_DEPTH).
REQ-024 Credit rule: a word is accepted only if it has a reserved buffer slot, so the FIFO never overflows.
REQ-025 Each up handshake SHALL decrement remaining; accepting the last word SHALL move the FSM to DRAIN on the next cycle.
REQ-026 In DRAIN, up_ready SHALL be 0.
REQ-027 DRAIN SHALL exit to IDLE when inflight==0 and the FIFO is empty, with done high for that one cycle.
REQ-028 In every state other than IDLE, cfg_ready SHALL be 0.
REQ-029 A 4-stage valid shift register SHALL track words through rescale; inflight is the population count of that register (0..4).
REQ-030 A word accepted in cycle t SHALL be written to the FIFO at the end of cycle t+4; with an empty FIFO, dn_valid SHALL go high in cycle t+5.
REQ-031 Data order SHALL be preserved.
REQ-032 Throughput SHALL be one word per cycle while dn_ready is held high.
REQ-033 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged; a pop on empty or a push on full SHALL never occur.
REQ-034 dn_valid SHALL stay high and dn_data SHALL stay stable until dn_ready is high.
REQ-035 Saturation and shift arithmetic SHALL be exactly those of the rescale instance: shift first, then clip to 0x7FFF or 0x8000 per head.

Reset
REQ-036 On rst, the following SHALL hold: state=IDLE, cfg_ready=1, up_ready=0, dn_valid=0, busy=0, done=0, valid pipe cleared, FIFO pointers and count = 0, remaining = 0, shift and head = 0.
REQ-037 Reset mid-job SHALL discard all in-flight and buffered words; rescale datapath registers are not reset, and stale data is ignored via the cleared valid pipe.

Structure
REQ-038 FSM state encodings and the RESCALE_LATENCY=4 constant SHALL live in the shared include header used by the coprocessor control blocks.
REQ-039 rescale_ctrl SHALL instantiate one sub-module, rescale; the FIFO, credit counter and FSM are implemented inline.

Verification
REQ-040 shift=4, head=15, count=1, up_data=0x000001230, dn_ready=1 -> dn_data=0x0123 with dn_valid in cycle t+5, followed by a done pulse.
REQ-041 head=15, up_data=0x000100000 -> 0x7FFF; up_data=0x1FFFF0000 -> 0x8000.
REQ-042 count=20 with dn_ready=0 -> exactly 8 words accepted, then up_ready=0; releasing dn_ready -> all 20 words out in order, busy falls, done pulses once.
REQ-043 count=0 descriptor -> no up_ready, done pulse one cycle later, cfg_ready held at 1.
REQ-044 cfg_valid asserted during ACTIVE -> ignored (cfg_ready=0), and the shift seen by in-flight words is unchanged.
REQ-045 rst asserted with 3 words in flight and 5 buffered -> the next cycle shows dn_valid=0 and state IDLE, and a new job produces no stale words.
